decode_stage_p: RTL and testbench

Parametrised successor decode stage for the 5-stage MIPS pipeline, placed between the fetch/decode register and the execute stage. Contains:
- register file, main/ALU decoder and immediate extension
- early branch resolution for BEQ and BNE, with 3-way forwarding into the comparator
- jump target generation
- decode-to-execute pipeline register with stall, flush and valid tracking

Data width is generic. Instruction and PC width stay at 32.

---
 rtl/decode_stage_p.sv | 255 +++++++++++++++++++++++++
 tb/tb_decode_stage_p.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_p.sv
// -----------------------------------------------------------------------------
// decode_stage_p
//   Decode stage of the 5-stage MIPS pipeline: register file, main/ALU
//   decoder, immediate extension, early BEQ/BNE resolution with forwarding,
//   jump target generation and the decode-to-execute pipeline register.
//
// Parameters
//   WIDTH  datapath width (>=16)
//   NREGS  architectural registers (<=32, >=2); r0 and r>=NREGS read zero
//
// Optional feature
//   REGFILE_BYPASS_EN  when defined, register reads see the same-cycle
//                      writeback value (W-to-D bypass).
//
// Ports
//   clk, clr                 clock, synchronous active-high reset
//   instrD, pcplus4D, validD decode-slot instruction, PC+4, valid
//   stallE, flushE           E register hold / bubble insert
//   forwardAD/BD             comparator source: 0/3 regfile, 1 aluoutM, 2 resultW
//   aluoutM, resultW         forwarded values
//   regwriteW, writeregW     writeback port
//   rsD, rtD                 source register fields
//   branchD, jumpD, pcsrcD   branch/jump decode and branch outcome
//   pcbranchD, pcjumpD       branch and jump targets
//   illegalD                 undecoded instruction in a valid slot
//   *E                       registered execute-stage controls/operands
// -----------------------------------------------------------------------------
module decode_stage_p #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [31:0]       instrD,
   input  logic [31:0]       pcplus4D,
   input  logic              validD,
   input  logic              stallE,
   input  logic              flushE,
   input  logic [1:0]        forwardAD,
   input  logic [1:0]        forwardBD,
   input  logic [WIDTH-1:0]  aluoutM,
   input  logic [WIDTH-1:0]  resultW,
   input  logic              regwriteW,
   input  logic [4:0]        writeregW,
   output logic [4:0]        rsD,
   output logic [4:0]        rtD,
   output logic              branchD,
   output logic              jumpD,
   output logic              pcsrcD,
   output logic [31:0]       pcbranchD,
   output logic [31:0]       pcjumpD,
   output logic              illegalD,
   output logic              regwriteE,
   output logic              memtoregE,
   output logic              memwriteE,
   output logic              alusrcE,
   output logic              regdstE,
   output logic [2:0]        alucontrolE,
   output logic [WIDTH-1:0]  rd1E,
   output logic [WIDTH-1:0]  rd2E,
   output logic [WIDTH-1:0]  immE,
   output logic [4:0]        rsE,
   output logic [4:0]        rtE,
   output logic [4:0]        rdE,
   output logic              validE
);

   // ---------------------------------------------------------------- fields
   logic [5:0]  op, funct;
   logic [15:0] imm16;
   logic [4:0]  rdD;

   assign op    = instrD[31:26];
   assign funct = instrD[5:0];
   assign imm16 = instrD[15:0];
   assign rsD   = instrD[25:21];
   assign rtD   = instrD[20:16];
   assign rdD   = instrD[15:11];

   // --------------------------------------------------------- register file
   // Entry 0 is not stored; it and indices >= NREGS read as zero.
   logic [WIDTH-1:0] rf_q [1:NREGS-1];

   for (genvar r = 1; r < NREGS; r++) begin : g_rf
      always_ff @(posedge clk) begin
         if (regwriteW && writeregW == 5'(r))
            rf_q[r] <= resultW;
      end
   end

   logic [WIDTH-1:0] rd1, rd2;

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      for (int r = 1; r < NREGS; r++) begin
         if (rsD == 5'(r)) rd1 = rf_q[r];
         if (rtD == 5'(r)) rd2 = rf_q[r];
      end
`ifdef REGFILE_BYPASS_EN
      // Same-cycle writeback is visible to decode, so W-to-D needs no stall.
      if (regwriteW && writeregW == rsD && rsD != 5'd0) rd1 = resultW;
      if (regwriteW && writeregW == rtD && rtD != 5'd0) rd2 = resultW;
`endif
   end

   // --------------------------------------------------------------- decoder
   logic       dec_regwrite, dec_memtoreg, dec_memwrite, dec_alusrc, dec_regdst;
   logic       dec_beq, dec_bne, dec_j, dec_zext, dec_legal;
   logic [2:0] dec_aluctl;

   always_comb begin
      dec_regwrite = 1'b0;
      dec_memtoreg = 1'b0;
      dec_memwrite = 1'b0;
      dec_alusrc   = 1'b0;
      dec_regdst   = 1'b0;
      dec_beq      = 1'b0;
      dec_bne      = 1'b0;
      dec_j        = 1'b0;
      dec_zext     = 1'b0;
      dec_legal    = 1'b1;
      dec_aluctl   = 3'b000;
      unique case (op)
         6'b000000: begin
            dec_regwrite = 1'b1;
            dec_regdst   = 1'b1;
            unique case (funct)
               6'b100000: dec_aluctl = 3'b010;
               6'b100010: dec_aluctl = 3'b110;
               6'b100100: dec_aluctl = 3'b000;
               6'b100101: dec_aluctl = 3'b001;
               6'b101010: dec_aluctl = 3'b111;
               default: begin
                  dec_legal    = 1'b0;
                  dec_regwrite = 1'b0;
                  dec_regdst   = 1'b0;
               end
            endcase
         end
         6'b100011: begin // lw
            dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_memtoreg = 1'b1;
            dec_aluctl   = 3'b010;
         end
         6'b101011: begin // sw
            dec_memwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctl = 3'b010;
         end
         6'b000100: begin dec_beq = 1'b1; dec_aluctl = 3'b110; end
         6'b000101: begin dec_bne = 1'b1; dec_aluctl = 3'b110; end
         6'b001000: begin // addi
            dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluctl = 3'b010;
         end
         6'b001100: begin // andi
            dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_zext = 1'b1;
            dec_aluctl   = 3'b000;
         end
         6'b001101: begin // ori
            dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_zext = 1'b1;
            dec_aluctl   = 3'b001;
         end
         6'b000010: dec_j = 1'b1;
         default:   dec_legal = 1'b0;
      endcase
   end

   assign illegalD = validD & ~dec_legal;
   assign branchD  = validD & (dec_beq | dec_bne);
   assign jumpD    = validD & dec_j;

   logic [WIDTH-1:0] immext;
   assign immext = dec_zext ? WIDTH'(imm16) : WIDTH'($signed(imm16));

   // ------------------------------------------------- branch / jump targets
   logic [31:0] imm_sh;
   assign imm_sh    = {{14{imm16[15]}}, imm16, 2'b00};
   assign pcbranchD = pcplus4D + imm_sh;
   assign pcjumpD   = {pcplus4D[31:28], instrD[25:0], 2'b00};

   logic [WIDTH-1:0] cmp_a, cmp_b;
   logic             eq;

   always_comb begin
      unique case (forwardAD)
         2'd1:    cmp_a = aluoutM;
         2'd2:    cmp_a = resultW;
         default: cmp_a = rd1;
      endcase
      unique case (forwardBD)
         2'd1:    cmp_b = aluoutM;
         2'd2:    cmp_b = resultW;
         default: cmp_b = rd2;
      endcase
   end

   assign eq     = (cmp_a == cmp_b);
   assign pcsrcD = validD & ((dec_beq & eq) | (dec_bne & ~eq));

   // ---------------------------------------------------- D/E pipeline reg
   // A D slot that is invalid or illegal still loads its data fields but
   // carries no controls into E.
   logic ok;
   assign ok = validD & dec_legal;

   logic             regwrite_q, memtoreg_q, memwrite_q, alusrc_q, regdst_q, valid_q;
   logic [2:0]       aluctl_q;
   logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;
   logic [4:0]       rs_q, rt_q, rd_q;

   always_ff @(posedge clk) begin
      if (clr || flushE) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         regdst_q   <= 1'b0;
         aluctl_q   <= 3'b000;
         valid_q    <= 1'b0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
      end else if (!stallE) begin
         regwrite_q <= ok & dec_regwrite;
         memtoreg_q <= ok & dec_memtoreg;
         memwrite_q <= ok & dec_memwrite;
         alusrc_q   <= ok & dec_alusrc;
         regdst_q   <= ok & dec_regdst;
         aluctl_q   <= ok ? dec_aluctl : 3'b000;
         valid_q    <= ok;
         rd1_q      <= rd1;
         rd2_q      <= rd2;
         imm_q      <= immext;
         rs_q       <= rsD;
         rt_q       <= rtD;
         rd_q       <= rdD;
      end
   end

   assign regwriteE   = regwrite_q;
   assign memtoregE   = memtoreg_q;
   assign memwriteE   = memwrite_q;
   assign alusrcE     = alusrc_q;
   assign regdstE     = regdst_q;
   assign alucontrolE = aluctl_q;
   assign validE      = valid_q;
   assign rd1E        = rd1_q;
   assign rd2E        = rd2_q;
   assign immE        = imm_q;
   assign rsE         = rs_q;
   assign rtE         = rt_q;
   assign rdE         = rd_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_p
//   Directed bench for decode_stage_p (WIDTH=32, NREGS=32). Expectations are
//   hand-computed; the bypass case follows REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_decode_stage_p;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          clr;
   logic [31:0]   instrD, pcplus4D;
   logic          validD, stallE, flushE;
   logic [1:0]    forwardAD, forwardBD;
   logic [W-1:0]  aluoutM, resultW;
   logic          regwriteW;
   logic [4:0]    writeregW;
   logic [4:0]    rsD, rtD;
   logic          branchD, jumpD, pcsrcD, illegalD;
   logic [31:0]   pcbranchD, pcjumpD;
   logic          regwriteE, memtoregE, memwriteE, alusrcE, regdstE, validE;
   logic [2:0]    alucontrolE;
   logic [W-1:0]  rd1E, rd2E, immE;
   logic [4:0]    rsE, rtE, rdE;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decode_stage_p #(.WIDTH(W), .NREGS(32)) dut (
      .clk(clk), .clr(clr), .instrD(instrD), .pcplus4D(pcplus4D),
      .validD(validD), .stallE(stallE), .flushE(flushE),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .aluoutM(aluoutM), .resultW(resultW),
      .regwriteW(regwriteW), .writeregW(writeregW),
      .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
      .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
      .illegalD(illegalD), .regwriteE(regwriteE), .memtoregE(memtoregE),
      .memwriteE(memwriteE), .alusrcE(alusrcE), .regdstE(regdstE),
      .alucontrolE(alucontrolE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
      .rsE(rsE), .rtE(rtE), .rdE(rdE), .validE(validE)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [W-1:0] v);
      regwriteW = 1'b1; writeregW = r; resultW = v;
      step();
      regwriteW = 1'b0; writeregW = 5'd0;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [2:0] alu_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
   logic [W-1:0] exp_byp;

   initial begin
      clr = 1'b1; stallE = 1'b1; flushE = 1'b0; validD = 1'b1;
      instrD = itype(6'b001000, 5'd1, 5'd2, 16'h1234); pcplus4D = 32'h0;
      forwardAD = 2'd0; forwardBD = 2'd0; aluoutM = '0; resultW = '0;
      regwriteW = 1'b0; writeregW = 5'd0;

      // ---- reset (with stall asserted)
      step(); step();
      check("rst_ctl", {regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE, validE}, 0);
      check("rst_data", {rd1E, rd2E}, 0);
      check("rst_imm_idx", {immE, rsE, rtE, rdE}, 0);
      clr = 1'b0; stallE = 1'b0; validD = 1'b0;

      // ---- branch resolution from the register file
      wr(5'd8, 5); wr(5'd9, 5);
      validD = 1'b1; pcplus4D = 32'h100;
      instrD = itype(6'b000100, 5'd8, 5'd9, 16'd3);
      #1;
      check("beq_taken", pcsrcD, 1);
      check("beq_target", pcbranchD, 32'h10C);
      check("beq_branchD", branchD, 1);
      check("beq_rs_rt", {rsD, rtD}, {5'd8, 5'd9});
      instrD = itype(6'b000101, 5'd8, 5'd9, 16'd3);
      #1;
      check("bne_not_taken", pcsrcD, 0);
      instrD = itype(6'b000100, 5'd8, 5'd9, 16'hFFFF);
      #1;
      check("beq_neg_target", pcbranchD, 32'hFC);
      validD = 1'b0;
      #1;
      check("beq_invalid", {pcsrcD, branchD}, 0);
      validD = 1'b1;

      // ---- comparator forwarding
      wr(5'd8, 1); wr(5'd9, 7);
      aluoutM = 7; resultW = 7;
      instrD = itype(6'b000100, 5'd8, 5'd9, 16'd3);
      forwardAD = 2'd1; #1; check("fwd_a_mem", pcsrcD, 1);
      forwardAD = 2'd2; #1; check("fwd_a_wb", pcsrcD, 1);
      forwardAD = 2'd0; #1; check("fwd_a_rf", pcsrcD, 0);
      forwardAD = 2'd3; #1; check("fwd_a_rf3", pcsrcD, 0);
      forwardAD = 2'd0; forwardBD = 2'd1; aluoutM = 1;
      #1; check("fwd_b_mem", pcsrcD, 1);
      forwardBD = 2'd0;

      // ---- pipeline register: addi / ori
      instrD = itype(6'b001000, 5'd0, 5'd10, 16'hFFFF);
      step();
      check("addi_ctl", {regwriteE, alusrcE, regdstE, memwriteE, memtoregE, alucontrolE, validE},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1});
      check("addi_imm", immE, {W{1'b1}});
      check("addi_rt", rtE, 10);
      instrD = itype(6'b001101, 5'd0, 5'd10, 16'hFFFF);
      step();
      check("ori_imm", immE, 32'h0000FFFF);
      check("ori_alu", alucontrolE, 3'b001);

      // ---- stall holds, then stall+flush gives a bubble
      stallE = 1'b1;
      instrD = rtype(5'd8, 5'd9, 5'd3, 6'b100010);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold", {immE, alucontrolE, rtE, validE, regwriteE},
               {32'h0000FFFF, 3'b001, 5'd10, 1'b1, 1'b1});
      end
      flushE = 1'b1;
      step();
      check("flush_bubble", {validE, regwriteE, alusrcE, alucontrolE, immE, rtE}, 0);
      flushE = 1'b0; stallE = 1'b0;

      // ---- R-type ALU control table
      for (int i = 0; i < 5; i++) begin
         instrD = rtype(5'd8, 5'd9, 5'd4, fn_tab[i]);
         step();
         check("rtype_alu", {alucontrolE, regdstE, regwriteE, alusrcE, rdE},
               {alu_tab[i], 1'b1, 1'b1, 1'b0, 5'd4});
      end
      check("rtype_data", {rd1E, rd2E}, {32'd1, 32'd7});

      // ---- lw / sw controls
      instrD = itype(6'b100011, 5'd9, 5'd2, 16'h8000);
      step();
      check("lw_ctl", {memtoregE, regwriteE, alusrcE, memwriteE, alucontrolE}, {4'b1110, 3'b010});
      check("lw_imm", immE, 32'hFFFF8000);
      instrD = itype(6'b101011, 5'd9, 5'd2, 16'h0010);
      step();
      check("sw_ctl", {memtoregE, regwriteE, alusrcE, memwriteE}, 4'b0011);

      // ---- illegal opcode / funct / invalid slot
      instrD = {6'b111111, 5'd5, 5'd6, 16'h0};
      #1;
      check("illegal_op", {illegalD, branchD, jumpD}, 3'b100);
      step();
      check("illegal_bubble", {validE, regwriteE, alucontrolE}, 0);
      check("illegal_fields", {rsE, rtE}, {5'd5, 5'd6});
      instrD = rtype(5'd8, 5'd9, 5'd3, 6'b111111);
      #1;
      check("illegal_funct", illegalD, 1);
      instrD = rtype(5'd8, 5'd9, 5'd3, 6'b100000);
      validD = 1'b0;
      #1;
      check("invalid_not_illegal", illegalD, 0);
      step();
      check("invalid_bubble", {validE, regwriteE, regdstE}, 0);
      validD = 1'b1;

      // ---- jump target
      instrD = {6'b000010, 26'h0000040}; pcplus4D = 32'h40000004;
      #1;
      check("jump", {jumpD, pcjumpD}, {1'b1, 32'h40000100});

      // ---- W-to-D same-cycle dependency (R8 holds 1)
      regwriteW = 1'b1; writeregW = 5'd8; resultW = 32'hA5;
      instrD = rtype(5'd8, 5'd0, 5'd3, 6'b100000);
`ifdef REGFILE_BYPASS_EN
      exp_byp = 32'hA5;
`else
      exp_byp = 32'd1;
`endif
      step();
      check("bypass_rd1", rd1E, exp_byp);
      writeregW = 5'd0; resultW = 32'h33;
      instrD = rtype(5'd0, 5'd8, 5'd3, 6'b100000);
      step();
      check("r0_zero", {rd1E, rd2E}, {32'd0, 32'hA5});
      regwriteW = 1'b0;

      // ---- clr mid-stall clears E; regfile write on clr edge still lands
      stallE = 1'b1; clr = 1'b1;
      regwriteW = 1'b1; writeregW = 5'd9; resultW = 32'h77;
      step();
      check("clr_mid_stall", {validE, regwriteE, rd2E, rdE}, 0);
      clr = 1'b0; stallE = 1'b0; regwriteW = 1'b0; writeregW = 5'd0;
      instrD = rtype(5'd8, 5'd9, 5'd3, 6'b100000);
      step();
      check("write_on_clr", {rd1E, rd2E}, {32'hA5, 32'h77});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
